// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the ALU sequencer: opcode and FSM state encodings,
// plus a helper that recognises the opcodes routed to the divider.
package alu_seq_pkg;

    // Opcode literals carry an OP_ prefix so they cannot collide with the
    // DIV state name below.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SLL = 4'd8,
        OP_SRL = 4'd9
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Highest legal opcode; anything above it is reported as an error.
    localparam int OP_LAST = 9;

    function automatic logic isDivOp(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command/response bundle between the datapath and the ALU sequencer.
// The master issues commands and consumes results; the slave is the sequencer.
interface alu_seq_ctrl_if #(parameter int M = 4);

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_a;
    logic [M-1:0] in_b;
    logic [3:0]   in_op;

    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_q;
    logic         out_z;
    logic         out_n;
    logic         out_c;
    logic         out_v;
    logic         out_dz;
    logic         out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_q, out_z, out_n, out_c, out_v, out_dz, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_q, out_z, out_n, out_c, out_v, out_dz, out_err
    );

endinterface

// File: rtl/alu_seq_ctrl_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The first bit is
// resolved on the start edge itself, so the final quotient/remainder are in
// the registers M-1 edges later, flagged by a one-cycle done pulse.
module seq_divider #(
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [M-1:0] i_dividend,
    input  logic [M-1:0] i_divisor,
    output logic [M-1:0] o_quotient,
    output logic [M-1:0] o_remainder,
    output logic         o_done
);

    localparam int CW = $clog2(M + 1);

    logic [M-1:0]  r_quo;
    logic [M-1:0]  r_rem;
    logic [M-1:0]  r_div;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor, keep the difference only if it did not
    // borrow. Returns {remainder, quotient}.
    function automatic logic [2*M-1:0] divStep(
        input logic [M-1:0] rem,
        input logic [M-1:0] quo,
        input logic [M-1:0] dvs
    );
        logic [M:0] shifted;
        logic [M:0] trial;
        shifted = {rem, quo[M-1]};
        trial   = shifted - {1'b0, dvs};
        if (trial[M]) begin
            divStep = {shifted[M-1:0], quo[M-2:0], 1'b0};
        end else begin
            divStep = {trial[M-1:0], quo[M-2:0], 1'b1};
        end
    endfunction

    // Load-and-first-step on start, then one step per clock until the count runs out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            {r_rem, r_quo} <= divStep('0, i_dividend, i_divisor);
            r_div  <= i_divisor;
            r_cnt  <= CW'(M - 1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            {r_rem, r_quo} <= divStep(r_rem, r_quo, r_div);
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done      = r_done;

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: accepts one command per handshake, evaluates single-cycle
// operations inline and hands divide/modulo to the iterative divider, then
// presents a registered result with flags until the consumer takes it.
module alu_seq_ctrl #(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_seq_ctrl_if.slave bus
);

    import alu_seq_pkg::*;

    localparam logic [M:0] SHIFT_LIMIT = (M + 1)'(M);

    state_t       r_state;
    logic [M-1:0] r_q;
    logic         r_z;
    logic         r_n;
    logic         r_c;
    logic         r_v;
    logic         r_dz;
    logic         r_err;
    logic         r_isMod;

    logic         w_inReady;
    logic         w_accept;
    logic         w_toDiv;
    logic         w_divStart;
    logic         w_divDone;
    logic [M-1:0] w_quo;
    logic [M-1:0] w_rem;

    logic [M:0]     w_sum;
    logic [M:0]     w_diff;
    logic [2*M-1:0] w_prod;
    logic           w_bigShift;
    logic           w_illegal;
    logic [M-1:0]   w_q;
    logic           w_c;
    logic           w_v;
    logic           w_dz;

    // In DONE a new command may only enter if the current result leaves at the same edge.
    assign w_inReady  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_inReady;
    assign w_toDiv    = isDivOp(bus.in_op) && (bus.in_b != '0);
    assign w_divStart = w_accept && w_toDiv;

    assign w_sum      = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign w_diff     = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    assign w_prod     = {{M{1'b0}}, bus.in_a} * {{M{1'b0}}, bus.in_b};
    assign w_bigShift = {1'b0, bus.in_b} >= SHIFT_LIMIT;
    assign w_illegal  = bus.in_op > 4'(OP_LAST);

    seq_divider #(.M(M)) u_div (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (w_divStart),
        .i_dividend  (bus.in_a),
        .i_divisor   (bus.in_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_done      (w_divDone)
    );

    // Single-cycle result and C/V/dz for the command currently on the bus;
    // DIV/MOD only land here with a zero divisor.
    always_comb begin
        w_q  = '0;
        w_c  = 1'b0;
        w_v  = 1'b0;
        w_dz = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                w_q = w_sum[M-1:0];
                w_c = w_sum[M];
                w_v = (bus.in_a[M-1] == bus.in_b[M-1]) && (w_sum[M-1] != bus.in_a[M-1]);
            end
            OP_SUB: begin
                w_q = w_diff[M-1:0];
                w_c = ~w_diff[M];
                w_v = (bus.in_a[M-1] != bus.in_b[M-1]) && (w_diff[M-1] != bus.in_a[M-1]);
            end
            OP_MUL: begin
                w_q = w_prod[M-1:0];
                w_v = |w_prod[2*M-1:M];
            end
            OP_DIV: begin
                w_q  = '1;
                w_dz = 1'b1;
            end
            OP_MOD: begin
                w_q  = bus.in_a;
                w_dz = 1'b1;
            end
            OP_AND: w_q = bus.in_a & bus.in_b;
            OP_OR:  w_q = bus.in_a | bus.in_b;
            OP_XOR: w_q = bus.in_a ^ bus.in_b;
            OP_SLL: w_q = w_bigShift ? '0 : (bus.in_a << bus.in_b);
            OP_SRL: w_q = w_bigShift ? '0 : (bus.in_a >> bus.in_b);
            default: w_q = '0;
        endcase
    end

    // Control FSM: route accepted commands, wait out the divider, hold results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= w_toDiv ? DIV : DONE;
                    end
                end
                DIV: begin
                    if (w_divDone) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (w_accept) begin
                        r_state <= w_toDiv ? DIV : DONE;
                    end else if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result registers: loaded on a single-cycle accept or when the divider finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_dz    <= 1'b0;
            r_err   <= 1'b0;
            r_isMod <= 1'b0;
        end else if (w_accept && !w_toDiv) begin
            r_q   <= w_q;
            r_z   <= (w_q == '0);
            r_n   <= w_q[M-1];
            r_c   <= w_c;
            r_v   <= w_v;
            r_dz  <= w_dz;
            r_err <= w_illegal;
        end else if (w_accept) begin
            r_isMod <= (bus.in_op == OP_MOD);
        end else if ((r_state == DIV) && w_divDone) begin
            r_q   <= r_isMod ? w_rem : w_quo;
            r_z   <= ((r_isMod ? w_rem : w_quo) == '0);
            r_n   <= r_isMod ? w_rem[M-1] : w_quo[M-1];
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_dz  <= 1'b0;
            r_err <= 1'b0;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_q     = r_q;
    assign bus.out_z     = r_z;
    assign bus.out_n     = r_n;
    assign bus.out_c     = r_c;
    assign bus.out_v     = r_v;
    assign bus.out_dz    = r_dz;
    assign bus.out_err   = r_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with M=4: directed commands push their
// hand-computed results, a monitor pops and compares on each handshake.
module tb_alu_seq_ctrl;

    import alu_seq_pkg::*;

    localparam int M = 4;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic [5:0] flags;
        int         acceptEdge;
        int         expLat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycle  = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sbQueue[$];

    int   presentEdge = 0;
    bit   holdPrev    = 0;
    int   dummy;
    int   waits;
    int   lowCount;
    int   validCount;

    alu_seq_ctrl_if #(.M(M)) bus ();

    alu_seq_ctrl #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock and edge counter used for latency bookkeeping.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkValue(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e, input int presentedAt);
        logic [5:0] gotFlags;
        gotFlags = {bus.out_z, bus.out_n, bus.out_c, bus.out_v, bus.out_dz, bus.out_err};
        checks++;
        if (bus.out_q !== e.q || gotFlags !== e.flags) begin
            errors++;
            $display("[TB] FAIL %s: got q=%h zncv_dz_err=%b, required q=%h zncv_dz_err=%b",
                     e.name, bus.out_q, gotFlags, e.q, e.flags);
        end
        checks++;
        if (presentedAt - e.acceptEdge != e.expLat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d edges, required %0d",
                     e.name, presentedAt - e.acceptEdge, e.expLat);
        end
    endtask

    // Issue one command, wait (bounded) for acceptance, optionally record its expected result.
    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic [3:0] q, input logic [5:0] flags,
                                 input int expLat, input bit doPush, output int waitCycles);
        bit   accepted;
        exp_t e;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        waitCycles   = 0;
        accepted     = 1'b0;
        for (int k = 0; k < 100 && !accepted; k++) begin
            @(negedge clk);
            if (bus.in_ready) accepted = 1'b1;
            else waitCycles++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s accept: got no handshake in 100 cycles, required acceptance", name);
        end else if (doPush) begin
            e.name       = name;
            e.q          = q;
            e.flags      = flags;
            e.acceptEdge = cycle;
            e.expLat     = expLat;
            sbQueue.push_back(e);
        end
    endtask

    task automatic drainQueue(input int maxCycles);
        for (int k = 0; k < maxCycles && sbQueue.size() != 0; k++) @(negedge clk);
        checkValue("drain", 16'(sbQueue.size()), 16'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: note when each result first appears, compare it on its handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            holdPrev = 1'b0;
        end else begin
            if (bus.out_valid && !holdPrev) presentEdge = cycle + 1;
            if (bus.out_valid && bus.out_ready) begin
                if (sbQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected: got result q=%h, required no output", bus.out_q);
                end else begin
                    checkOutput(sbQueue.pop_front(), presentEdge);
                end
                holdPrev = 1'b0;
            end else begin
                holdPrev = bus.out_valid;
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        checkValue("reset", 16'({bus.in_ready, bus.out_valid, bus.out_q, bus.out_z, bus.out_n,
                                 bus.out_c, bus.out_v, bus.out_dz, bus.out_err}),
                   16'({1'b1, 1'b0, 4'h0, 6'b000000}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops; flags are {z,n,c,v,dz,err}.
        applyStimulus("add7_9",  OP_ADD, 4'd7,  4'd9, 4'h0, 6'b101000, 1, 1'b1, dummy);
        applyStimulus("add7_1",  OP_ADD, 4'd7,  4'd1, 4'h8, 6'b010100, 1, 1'b1, dummy);
        applyStimulus("sub3_5",  OP_SUB, 4'd3,  4'd5, 4'hE, 6'b010000, 1, 1'b1, dummy);
        applyStimulus("sub5_3",  OP_SUB, 4'd5,  4'd3, 4'h2, 6'b001000, 1, 1'b1, dummy);
        applyStimulus("sub8_1",  OP_SUB, 4'd8,  4'd1, 4'h7, 6'b001100, 1, 1'b1, dummy);
        applyStimulus("sll3_5",  OP_SLL, 4'd3,  4'd5, 4'h0, 6'b100000, 1, 1'b1, dummy);
        applyStimulus("sll1_3",  OP_SLL, 4'd1,  4'd3, 4'h8, 6'b010000, 1, 1'b1, dummy);
        applyStimulus("srlF_4",  OP_SRL, 4'hF,  4'd4, 4'h0, 6'b100000, 1, 1'b1, dummy);
        applyStimulus("srl8_3",  OP_SRL, 4'h8,  4'd3, 4'h1, 6'b000000, 1, 1'b1, dummy);
        applyStimulus("andC_A",  OP_AND, 4'hC,  4'hA, 4'h8, 6'b010000, 1, 1'b1, dummy);
        applyStimulus("orC_3",   OP_OR,  4'hC,  4'h3, 4'hF, 6'b010000, 1, 1'b1, dummy);
        applyStimulus("mul5_3",  OP_MUL, 4'd5,  4'd3, 4'hF, 6'b010000, 1, 1'b1, dummy);

        // Iterative divide: in_ready must stay low for M cycles.
        applyStimulus("div13_3", OP_DIV, 4'd13, 4'd3, 4'h4, 6'b000000, 5, 1'b1, dummy);
        lowCount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            lowCount++;
        end
        checkValue("div_busy_cycles", 16'(lowCount), 16'd4);
        @(posedge clk);
        #1;
        applyStimulus("mod13_3", OP_MOD, 4'd13, 4'd3, 4'h1, 6'b000000, 5, 1'b1, dummy);
        applyStimulus("mod14_5", OP_MOD, 4'd14, 4'd5, 4'h4, 6'b000000, 5, 1'b1, dummy);
        applyStimulus("div15_1", OP_DIV, 4'd15, 4'd1, 4'hF, 6'b010000, 5, 1'b1, dummy);
        applyStimulus("div9_0",  OP_DIV, 4'd9,  4'd0, 4'hF, 6'b010010, 1, 1'b1, dummy);
        applyStimulus("mod9_0",  OP_MOD, 4'd9,  4'd0, 4'h9, 6'b010010, 1, 1'b1, dummy);
        applyStimulus("op12",    4'd12,  4'd5,  4'd3, 4'h0, 6'b100001, 1, 1'b1, dummy);
        drainQueue(50);

        // Backpressure: result must hold with in_ready low, then complete and accept together.
        bus.out_ready = 1'b0;
        applyStimulus("mul6_3",  OP_MUL, 4'd6,  4'd3, 4'h2, 6'b000100, 1, 1'b1, dummy);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkValue("hold_mul", 16'({bus.out_valid, bus.in_ready, bus.out_q, bus.out_v}),
                       16'({1'b1, 1'b0, 4'h2, 1'b1}));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus("add2_3",  OP_ADD, 4'd2,  4'd3, 4'h5, 6'b000000, 1, 1'b1, waits);
        checkValue("same_edge_accept", 16'(waits), 16'd0);
        drainQueue(50);

        // Reset during the second divide iteration must abort without any output.
        applyStimulus("div15_2", OP_DIV, 4'd15, 4'd2, 4'h7, 6'b000000, 5, 1'b0, dummy);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkValue("async_reset", 16'({bus.in_ready, bus.out_valid, bus.out_q, bus.out_z, bus.out_n,
                                       bus.out_c, bus.out_v, bus.out_dz, bus.out_err}),
                   16'({1'b1, 1'b0, 4'h0, 6'b000000}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        validCount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.out_valid) validCount++;
        end
        checkValue("no_stale_output", 16'(validCount), 16'd0);
        @(posedge clk);
        #1;
        applyStimulus("xorA_5",  OP_XOR, 4'hA,  4'h5, 4'hF, 6'b010000, 1, 1'b1, dummy);
        drainQueue(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequential front end for the datapath's ALU operations. It accepts one operation per handshake (operands A, B and an opcode), computes single-cycle operations combinationally, and runs divide/modulo as an iterative restoring division. It returns a registered result with Z/N/C/V and divide-by-zero flags over a valid/ready response channel. It is the command/response side that feeds operands to, and collects results from, the datapath.

## Interface
- `M`, default 4: operand/result width; M ≥ 2.
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: command valid.
- `in_ready`, out, 1: command accepted when `in_valid & in_ready`.
- `in_a`, in, M: operand A (unsigned unless noted).
- `in_b`, in, M: operand B (divisor or shift amount where relevant).
- `in_op`, in, 4: opcode, one of ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, AND=5, OR=6, XOR=7, SLL=8, SRL=9.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: result consumed when `out_valid & out_ready`.
- `out_q`, out, M: result.
- `out_z`, `out_n`, `out_c`, `out_v`, out, 1 each: zero, negative, carry, overflow.
- `out_dz`, out, 1: divide-by-zero.
- `out_err`, out, 1: illegal opcode.

## Operation
- FSM states: IDLE, DIV, DONE.
  - IDLE: on accept, a DIV/MOD with B≠0 goes to DIV; any other opcode goes to DONE.
  - DIV: runs M iterations, then goes to DONE.
  - DONE: holds outputs; on `out_ready` goes to IDLE, or accepts a new command in the same cycle.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`. `in_ready` is low throughout DIV.
- Operands and opcode are latched on accept. Inputs are don't-care at all other times.
- Result rules (all modulo 2^M):
  - ADD: `Q = A+B`; C = carry out; V = signed overflow.
  - SUB: `Q = A−B`; C = 1 when A ≥ B (no borrow); V = signed overflow.
  - MUL: `Q` = low M bits of A·B; V = 1 when the high M bits are nonzero; C = 0.
  - DIV: `Q = A/B` (unsigned). MOD: `Q = A%B`. B=0 gives DIV `Q` = all ones, MOD `Q = A`, `dz = 1`.
  - AND/OR/XOR: bitwise.
  - SLL/SRL: logical shift by B; B ≥ M gives Q = 0.
  - Opcodes 10–15: Q = 0, `err = 1`.
- Flag rules: Z = (Q==0) and N = Q[M−1] for every opcode. C and V are 0 for every opcode other than those listed above. `dz` and `err` are 0 unless set as above.
- Outputs are registered and stable while `out_valid` is high and `out_ready` is low.

## Timing
- Reset: state IDLE; `in_ready = 1`, `out_valid = 0`, `out_q = 0`, and all flags 0. Reset asserted at any point, including mid-DIV, aborts the operation immediately with no output.
- Single-cycle ops and B=0 divide: accepted at edge t, `out_valid` high after edge t+1.
- DIV/MOD with B≠0: accepted at edge t, M iteration edges follow, `out_valid` high after edge t+M+1.
- Back-to-back: `out_ready` high in DONE together with `in_valid` gives completion and acceptance at the same edge, so sustained throughput is one single-cycle op per cycle.
- `out_valid` stays high until the handshake and is never dropped or altered without `out_ready`.

## Structure
- Package `alu_seq_pkg` holds:
  - `op_t` opcode enum (4 bits, values as above),
  - `state_t` enum {IDLE, DIV, DONE},
  - localparam `OP_LAST = 9`.
- Sub-module `seq_divider #(M)`: restoring divider with `start`, latched dividend/divisor, quotient/remainder registers, an iteration counter of $clog2(M+1) bits, and a `done` pulse. The top-level FSM owns all handshaking. Single-cycle ops stay inline in the top level.

## Test plan
All scenarios use M=4.
- ADD A=7, B=9 -> one cycle later Q=0, Z=1, C=1, V=0, N=0. ADD 7+1 -> Q=8, V=1, N=1.
- SUB A=3, B=5 -> Q=0xE, N=1, C=0, V=0. SLL A=3, B=5 -> Q=0, Z=1.
- DIV 13/3 -> `in_ready` low for 4 cycles, Q=4 at t+5. MOD 13%3 -> Q=1 at t+5.
- DIV 9/0 -> Q=0xF, dz=1 at t+1. MOD 9/0 -> Q=9, dz=1. Opcode 12 -> Q=0, err=1, Z=1.
- Backpressure: hold `out_ready` low 5 cycles after a MUL of 6·3 -> Q=2, V=1 held stable with `in_ready` low. Then `out_ready` high together with a new ADD command -> completion and acceptance at the same edge, next result the following cycle.
- Pull `rst_n` low at iteration 2 of DIV 15/2, release, then issue XOR 0xA^0x5 -> no stale output, Q=0xF.
